// File: rtl/stage_writeback.sv
// Writeback stage: selects the retiring result, waits on load data,
// and drives the register-file write port back to decode.
module stage_writeback #(
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic        mem_regfile_wr_enable,
  input  logic [1:0]  mem_result_src,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_instr_addr_plus,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_rvalid,
  output logic [4:0]  wb_wr_addr,
  output logic [31:0] wb_wr_data,
  output logic        wb_regfile_wr_enable,
  output logic        wb_stall,
  output logic        wb_retire,
  output logic        wb_load_error
);

  localparam int CW =
    (LOAD_TIMEOUT < 2) ? 1 : $clog2(LOAD_TIMEOUT);
  localparam logic [CW-1:0] LAST =
    CW'(LOAD_TIMEOUT - 1);

  localparam logic [1:0] SRC_MEM = 2'b01;
  localparam logic [1:0] SRC_PC  = 2'b10;

  typedef enum logic {
    IDLE,
    WAIT_LOAD
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [4:0]    ld_rd, ld_rd_n;
  logic          ld_we, ld_we_n;
  logic [2:0]    ld_f3, ld_f3_n;
  logic [1:0]    ld_off, ld_off_n;

  logic [4:0]    addr_n;
  logic [31:0]   data_n;
  logic          we_n;
  logic          retire_n;
  logic          err_n;

  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_data;
  logic          timeout;

  assign wb_stall = (state == WAIT_LOAD) & ~dmem_rvalid;
  assign timeout  = (LOAD_TIMEOUT != 0) && (cnt == LAST);

  // Halfword loads use only offset[1]; misaligned low bit is dropped
  always_comb begin
    ld_byte = dmem_rdata[{ld_off, 3'b000} +: 8];
    ld_half = dmem_rdata[{ld_off[1], 4'b0000} +: 16];
    ld_data = dmem_rdata;
    unique case (1'b1)
      ld_f3 == 3'b000:
        ld_data = {{24{ld_byte[7]}}, ld_byte};
      ld_f3 == 3'b100:
        ld_data = {24'd0, ld_byte};
      ld_f3 == 3'b001:
        ld_data = {{16{ld_half[15]}}, ld_half};
      ld_f3 == 3'b101:
        ld_data = {16'd0, ld_half};
      default:
        ld_data = dmem_rdata;
    endcase
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    ld_rd_n  = ld_rd;
    ld_we_n  = ld_we;
    ld_f3_n  = ld_f3;
    ld_off_n = ld_off;
    addr_n   = wb_wr_addr;
    data_n   = wb_wr_data;
    we_n     = 1'b0;
    retire_n = 1'b0;
    err_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_valid) begin
          if (mem_result_src == SRC_MEM) begin
            ld_rd_n  = mem_rd;
            ld_we_n  = mem_regfile_wr_enable;
            ld_f3_n  = mem_funct3;
            ld_off_n = mem_alu_result[1:0];
            cnt_n    = '0;
            state_n  = WAIT_LOAD;
          end else begin
            addr_n   = mem_rd;
            data_n   = (mem_result_src == SRC_PC)
                     ? mem_instr_addr_plus
                     : mem_alu_result;
            we_n     = mem_regfile_wr_enable
                     & (mem_rd != 5'd0);
            retire_n = 1'b1;
          end
        end
      end
      WAIT_LOAD: begin
        if (dmem_rvalid) begin
          addr_n   = ld_rd;
          data_n   = ld_data;
          we_n     = ld_we & (ld_rd != 5'd0);
          retire_n = 1'b1;
          state_n  = IDLE;
        end else if (timeout) begin
          err_n    = 1'b1;
          state_n  = IDLE;
        end else begin
          cnt_n    = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      cnt                  <= '0;
      ld_rd                <= '0;
      ld_we                <= 1'b0;
      ld_f3                <= '0;
      ld_off               <= '0;
      wb_wr_addr           <= '0;
      wb_wr_data           <= '0;
      wb_regfile_wr_enable <= 1'b0;
      wb_retire            <= 1'b0;
      wb_load_error        <= 1'b0;
    end else begin
      state                <= state_n;
      cnt                  <= cnt_n;
      ld_rd                <= ld_rd_n;
      ld_we                <= ld_we_n;
      ld_f3                <= ld_f3_n;
      ld_off               <= ld_off_n;
      wb_wr_addr           <= addr_n;
      wb_wr_data           <= data_n;
      wb_regfile_wr_enable <= we_n;
      wb_retire            <= retire_n;
      wb_load_error        <= err_n;
    end
  end

endmodule
